// File: rtl/fetch_prefetch_unit_pkg.sv
// fetch_pkg: shared widths, defaults and entry type for the fetch stage
package fetch_pkg;
   localparam int XLEN_DEFAULT = 32;
   localparam int INST_BYTES = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// fetch_prefetch_unit_if: instruction-memory, redirect and decode-side signals of the fetch unit
interface fetch_prefetch_unit_if #(
   parameter int XLEN = fetch_pkg::XLEN_DEFAULT
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst_data;
   logic [XLEN-1:0] inst_pc;
   logic [XLEN-1:0] inst_pc_4;
   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_4,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_4,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/fetch_prefetch_unit_fifo.sv
// fetch_fifo: circular prefetch buffer with synchronous flush and wrap-bit pointers
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;
   logic [AW:0] wrPtr, rdPtr;
   logic [WIDTH-1:0] mem [DEPTH];
   assign count = wrPtr - rdPtr;
   assign empty = wrPtr == rdPtr;
   assign full = wrPtr == {~rdPtr[AW], rdPtr[AW-1:0]};
   assign popData = mem[rdPtr[AW-1:0]];
   // Pointer update; flush empties the buffer and overrides push and pop
   always_ff @(posedge clk or posedge reset)
      if (reset || flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + ONE;
         if (pop && !empty) rdPtr <= rdPtr + ONE;
      end
   // Storage is unreset: contents are only observed through popData while non-empty
   always_ff @(posedge clk)
      if (push && !flush) mem[wrPtr[AW-1:0]] <= pushData;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC generation, credit-limited pipelined fetch and prefetch buffering
module fetch_prefetch_unit import fetch_pkg::*; #(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int DEPTH = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input logic clk,
   input logic reset,
   fetch_prefetch_unit_if.master bus
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] ONE = 1;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);
   localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);
   logic [XLEN-1:0] fetchPc, respPc, targetPc;
   logic [CW-1:0] outstanding, outstandingNext, dropCnt;
   logic [AW:0] fifoCount;
   logic fifoFull, fifoEmpty, reqFire, push, pop;
   logic [2*XLEN-1:0] headEntry;
   // Credits come only from registered state so every accepted request owns a FIFO slot
   assign bus.imem_req_valid = (outstanding < MAX_OUT) && (32'(outstanding) + 32'(fifoCount) < DEPTH_U) && !reset;
   assign bus.imem_req_addr = fetchPc;
   assign reqFire = bus.imem_req_valid && bus.imem_req_ready;
   assign outstandingNext = outstanding + CW'(reqFire) - CW'(bus.imem_rsp_valid);
   assign push = bus.imem_rsp_valid && dropCnt == '0 && !bus.redirect_valid;
   assign pop = bus.inst_valid && bus.inst_ready;
   assign targetPc = bus.redirect_pc & ~XLEN'(3);
   assign bus.inst_valid = !fifoEmpty;
   assign bus.inst_pc = fifoEmpty ? '0 : headEntry[2*XLEN-1:XLEN];
   assign bus.inst_data = fifoEmpty ? '0 : headEntry[XLEN-1:0];
   assign bus.inst_pc_4 = fifoEmpty ? '0 : headEntry[2*XLEN-1:XLEN] + STEP;
   // PC, response-PC and credit/drop counters; a redirect retargets both PCs and marks all in-flight words stale
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         fetchPc <= RESET_PC;
         respPc <= RESET_PC;
         outstanding <= '0;
         dropCnt <= '0;
      end else begin
         outstanding <= outstandingNext;
         if (bus.redirect_valid) begin
            fetchPc <= targetPc;
            respPc <= targetPc;
            dropCnt <= outstandingNext;
         end else begin
            if (reqFire) fetchPc <= fetchPc + STEP;
            if (push) respPc <= respPc + STEP;
            if (bus.imem_rsp_valid && dropCnt != '0) dropCnt <= dropCnt - ONE;
         end
      end
   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) fifo (
      .clk(clk),
      .reset(reset),
      .flush(bus.redirect_valid),
      .push(push),
      .pushData({respPc, bus.imem_rsp_data}),
      .pop(pop),
      .popData(headEntry),
      .count(fifoCount),
      .full(fifoFull),
      .empty(fifoEmpty)
   );
   noOverflow: assert property (@(posedge clk) disable iff (reset) !(push && fifoFull && !pop));
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed checks of fetch, credit limit, redirect, wrap and async reset
module tb_fetch_prefetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic memReady = 1'b1;
   logic instReady = 1'b1;
   logic redirValid = 1'b0;
   logic [31:0] redirPc = '0;
   logic rspValid = 1'b0;
   logic [31:0] rspData = '0;
   int checks = 0;
   int failures = 0;
   int lat = 1;
   int cyc = 0;
   int fireCnt = 0;
   int qWr = 0;
   int qRd = 0;
   int base;
   logic [31:0] qAddr [64];
   int qDue [64];
   always #5 clk = ~clk;
   fetch_prefetch_unit_if #(.XLEN(32)) bus ();
   assign bus.imem_req_ready = memReady;
   assign bus.imem_rsp_valid = rspValid;
   assign bus.imem_rsp_data = rspData;
   assign bus.redirect_valid = redirValid;
   assign bus.redirect_pc = redirPc;
   assign bus.inst_ready = instReady;
   fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   // Memory model: records accepted requests, held in reset alongside the DUT
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) qRd <= qWr;
      else begin
         if (bus.imem_req_valid && memReady) begin
            qAddr[qWr % 64] <= bus.imem_req_addr;
            qDue[qWr % 64] <= cyc + lat;
            qWr <= qWr + 1;
            fireCnt <= fireCnt + 1;
         end
         if (rspValid) qRd <= qRd + 1;
      end
   end
   // In-order responses once due; instruction word is the bitwise inverse of its address
   always @(negedge clk) begin
      rspValid <= !reset && qRd != qWr && qDue[qRd % 64] <= cyc;
      rspData <= ~qAddr[qRd % 64];
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask
   task automatic waitInst();
      for (int i = 0; i < 20 && !bus.inst_valid; i++) @(negedge clk);
   endtask
   initial begin
      step(2);
      check("rst_req_valid", bus.imem_req_valid, 0);
      check("rst_inst_valid", bus.inst_valid, 0);
      check("rst_addr", bus.imem_req_addr, 0);
      check("rst_data", bus.inst_data, 0);
      check("rst_pc", bus.inst_pc, 0);
      check("rst_pc4", bus.inst_pc_4, 0);
      reset = 1'b0;
      #1;
      check("first_req_valid", bus.imem_req_valid, 1);
      check("first_addr", bus.imem_req_addr, 0);
      step;
      check("second_addr", bus.imem_req_addr, 32'h4);
      check("no_bypass", bus.inst_valid, 0);
      step;
      check("third_addr", bus.imem_req_addr, 32'h8);
      check("lat_inst_valid", bus.inst_valid, 1);
      check("lat_inst_pc", bus.inst_pc, 0);
      check("lat_inst_pc4", bus.inst_pc_4, 32'h4);
      check("lat_inst_data", bus.inst_data, 32'hFFFF_FFFF);
      step;
      check("stream_pc1", bus.inst_pc, 32'h4);
      check("stream_addr", bus.imem_req_addr, 32'hC);
      step;
      check("stream_pc2", bus.inst_pc, 32'h8);
      reset = 1'b1;
      instReady = 1'b0;
      step(2);
      reset = 1'b0;
      base = fireCnt;
      step(8);
      check("full_fires", fireCnt - base, 4);
      check("full_req_valid", bus.imem_req_valid, 0);
      check("full_inst_valid", bus.inst_valid, 1);
      check("full_head_pc", bus.inst_pc, 0);
      instReady = 1'b1;
      step;
      instReady = 1'b0;
      check("pop_req_valid", bus.imem_req_valid, 1);
      check("pop_req_addr", bus.imem_req_addr, 32'h10);
      check("pop_head_pc", bus.inst_pc, 32'h4);
      step;
      check("pop_fires", fireCnt - base, 5);
      check("pop_req_stop", bus.imem_req_valid, 0);
      reset = 1'b1;
      memReady = 1'b0;
      instReady = 1'b1;
      step(2);
      reset = 1'b0;
      redirValid = 1'b1;
      redirPc = 32'h10;
      step;
      redirValid = 1'b0;
      lat = 3;
      memReady = 1'b1;
      check("idle_redir_addr", bus.imem_req_addr, 32'h10);
      step(2);
      check("lat3_credit_stop", bus.imem_req_valid, 0);
      check("lat3_addr", bus.imem_req_addr, 32'h18);
      redirValid = 1'b1;
      redirPc = 32'h103;
      step;
      redirValid = 1'b0;
      check("redir_align_addr", bus.imem_req_addr, 32'h100);
      check("redir_inst_valid", bus.inst_valid, 0);
      step;
      check("redir_req_valid", bus.imem_req_valid, 1);
      check("redir_req_addr", bus.imem_req_addr, 32'h100);
      waitInst();
      check("redir_wait", bus.inst_valid, 1);
      check("redir_first_pc", bus.inst_pc, 32'h100);
      check("redir_first_data", bus.inst_data, ~32'h100);
      reset = 1'b1;
      lat = 1;
      step(2);
      reset = 1'b0;
      step(2);
      check("same_pre_pc", bus.inst_pc, 0);
      redirValid = 1'b1;
      redirPc = 32'h200;
      step;
      redirValid = 1'b0;
      check("same_flush", bus.inst_valid, 0);
      check("same_addr", bus.imem_req_addr, 32'h200);
      step;
      check("same_drop", bus.inst_valid, 0);
      step;
      check("same_valid", bus.inst_valid, 1);
      check("same_pc", bus.inst_pc, 32'h200);
      check("same_pc4", bus.inst_pc_4, 32'h204);
      check("same_data", bus.inst_data, ~32'h200);
      step;
      check("same_next_pc", bus.inst_pc, 32'h204);
      redirValid = 1'b1;
      redirPc = 32'hFFFF_FFFC;
      step;
      redirValid = 1'b0;
      check("wrap_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
      step;
      check("wrap_addr_zero", bus.imem_req_addr, 0);
      check("wrap_drop", bus.inst_valid, 0);
      step;
      check("wrap_pc", bus.inst_pc, 32'hFFFF_FFFC);
      check("wrap_pc4", bus.inst_pc_4, 0);
      step;
      check("wrap_next_pc", bus.inst_pc, 0);
      check("wrap_next_pc4", bus.inst_pc_4, 32'h4);
      reset = 1'b1;
      instReady = 1'b0;
      step(2);
      reset = 1'b0;
      step(3);
      check("mid_inst_valid", bus.inst_valid, 1);
      check("mid_req_valid", bus.imem_req_valid, 1);
      reset = 1'b1;
      #1;
      check("async_inst_valid", bus.inst_valid, 0);
      check("async_req_valid", bus.imem_req_valid, 0);
      check("async_addr", bus.imem_req_addr, 0);
      check("async_pc", bus.inst_pc, 0);
      step(2);
      instReady = 1'b1;
      reset = 1'b0;
      #1;
      check("restart_req_valid", bus.imem_req_valid, 1);
      check("restart_addr", bus.imem_req_addr, 0);
      step(2);
      check("restart_inst_valid", bus.inst_valid, 1);
      check("restart_pc", bus.inst_pc, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
